// File: rtl/ex_mem_stage_if.sv
// EX-to-MEM bus for the pipeline register: the EX-side inputs, the stall/flush
// controls and the registered MEM-side outputs, flags and halt status.
interface ex_mem_stage_if;
   logic        stall;
   logic        flush;
   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [15:0] ex_alu_out;
   logic        ex_ovfl;
   logic [15:0] ex_store_data;
   logic [3:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        mem_valid;
   logic [15:0] mem_alu_out;
   logic [15:0] mem_store_data;
   logic [3:0]  mem_rd;
   logic        mem_reg_write;
   logic        mem_mem_read;
   logic        mem_mem_write;
   logic [2:0]  flags;
   logic        halted;

   // The pipeline stage itself
   modport slave (
      input  stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_ovfl,
             ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
      output mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, flags, halted
   );

   // The execute stage / hazard controller driving it
   modport master (
      output stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_ovfl,
             ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
      input  mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, flags, halted
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural {Z,V,N} flag register and
// the sticky halt latch; supports stall (hold), flush (bubble) and halt freeze.
module ex_mem_stage (
   input  logic          clk,
   input  logic          rst_n,
   ex_mem_stage_if.slave bus
);
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   logic        valid_reg;
   logic [15:0] alu_out_reg;
   logic [15:0] store_data_reg;
   logic [3:0]  rd_reg;
   logic        reg_write_reg;
   logic        mem_read_reg;
   logic        mem_write_reg;
   logic [2:0]  flags_reg;
   logic        halted_reg;

   logic cap;
   logic real_cap;
   logic res_zero;

   // Halt freezes the stage just like a permanent stall
   assign cap      = !bus.stall && !halted_reg;
   assign real_cap = cap && !bus.flush && bus.ex_valid;
   assign res_zero = (bus.ex_alu_out == 16'h0000);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg      <= 1'b0;
         alu_out_reg    <= 16'h0000;
         store_data_reg <= 16'h0000;
         rd_reg         <= 4'h0;
         reg_write_reg  <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         flags_reg      <= 3'b000;
         halted_reg     <= 1'b0;
      end else if (cap) begin
         if (bus.flush) begin
            valid_reg      <= 1'b0;
            alu_out_reg    <= 16'h0000;
            store_data_reg <= 16'h0000;
            rd_reg         <= 4'h0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
         end else begin
            valid_reg      <= bus.ex_valid;
            alu_out_reg    <= bus.ex_alu_out;
            store_data_reg <= bus.ex_store_data;
            rd_reg         <= bus.ex_rd;
            // Controls of an invalid slot must never reach MEM
            reg_write_reg  <= bus.ex_reg_write & bus.ex_valid;
            mem_read_reg   <= bus.ex_mem_read & bus.ex_valid;
            mem_write_reg  <= bus.ex_mem_write & bus.ex_valid;
         end

         if (real_cap) begin
            case (bus.ex_opcode)
               OP_ADD, OP_SUB:
                  flags_reg <= {res_zero, bus.ex_ovfl, bus.ex_alu_out[15]};
               OP_XOR, OP_SLL, OP_SRA, OP_ROR:
                  flags_reg[2] <= res_zero;
               default: ;
            endcase
            if (bus.ex_opcode == OP_HLT)
               halted_reg <= 1'b1;
         end
      end
   end

   assign bus.mem_valid      = valid_reg;
   assign bus.mem_alu_out    = alu_out_reg;
   assign bus.mem_store_data = store_data_reg;
   assign bus.mem_rd         = rd_reg;
   assign bus.mem_reg_write  = reg_write_reg;
   assign bus.mem_mem_read   = mem_read_reg;
   assign bus.mem_mem_write  = mem_write_reg;
   assign bus.flags          = flags_reg;
   assign bus.halted         = halted_reg;
endmodule
